// File: rtl/ram_burst_reader.sv
// ram_burst_reader: streams LEN consecutive words from a registered-output RAM onto a
// valid/ready port. Read path: ram_addr register -> RAM output register -> 2-entry FIFO.
module ram_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done_tick,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  addr_vld_q, addr_vld_d;
  logic                  q_vld_q, q_vld_d;
  logic [DATA_WIDTH-1:0] entry0_q, entry0_d, entry1_q, entry1_d;
  logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  pop, push, hold, issue;
  logic [2:0]            occ;

  assign m_valid   = (count_q != 2'd0);
  assign m_data    = rd_ptr_q ? entry1_q : entry0_q;
  assign ram_addr  = addr_q;
  assign ram_we    = 1'b0;
  assign busy      = (state_q != IDLE);
  assign done_tick = (state_q == DONE);

  // occ counts words already owed to the consumer: FIFO contents, the word on ram_q and the
  // address about to be sampled. When the FIFO is full and a word sits on ram_q, ram_addr is
  // left unchanged so the RAM re-reads the same location and ram_q keeps that word.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    issue      = 1'b0;
    pop        = m_valid & m_ready;
    push       = q_vld_q && ((count_q - {1'b0, pop}) != 2'd2);
    hold       = q_vld_q && !push;
    occ        = {1'b0, count_q} + {2'b00, addr_vld_q} + {2'b00, q_vld_q} - {2'b00, pop};

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_d = DONE;
          end else begin
            issue   = 1'b1;
            addr_d  = base_addr;
            rem_d   = len - LEN_ONE;
            state_d = READ;
          end
        end
      end
      READ: begin
        if (rem_q == '0) begin
          state_d = DRAIN;
        end else if (occ < 3'd3) begin
          issue  = 1'b1;
          addr_d = addr_q + ADDR_ONE;
          rem_d  = rem_q - LEN_ONE;
        end
      end
      DRAIN: begin
        if (!addr_vld_q && !q_vld_q && ((count_q - {1'b0, pop}) == 2'd0)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    addr_vld_d = issue;
    q_vld_d    = addr_vld_q | hold;

    entry0_d = entry0_q;
    entry1_d = entry1_q;
    if (push && !wr_ptr_q) entry0_d = ram_q;
    if (push && wr_ptr_q)  entry1_d = ram_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      addr_vld_q <= 1'b0;
      q_vld_q    <= 1'b0;
      entry0_q   <= '0;
      entry1_q   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      addr_vld_q <= addr_vld_d;
      q_vld_q    <= q_vld_d;
      entry0_q   <= entry0_d;
      entry1_q   <= entry1_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Scoreboard bench for ram_burst_reader: bursts push expected words, a negedge monitor
// pops and compares every accepted stream word.
module tb_ram_burst_reader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] len;
  logic        busy;
  logic        done_tick;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_q;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;

  logic [7:0]  mem [1024];
  logic [7:0]  exp_q [$];
  int          errors = 0;
  int          checks = 0;
  int          accepted = 0;
  bit          track_en = 0;
  logic [9:0]  cur_base = '0;
  bit          stalled = 0;
  logic [7:0]  held_data = '0;
  bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  ram_burst_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .busy     (busy),
    .done_tick(done_tick),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_q    (ram_q),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM with registered read data.
  initial for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
  always @(posedge clk) ram_q <= mem[ram_addr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: stall stability, address lead over accepted words, and scoreboard pops.
  always @(negedge clk) begin
    logic [9:0] idx;
    if (!reset_n) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        checkOutput("hold_valid", m_valid, 1);
        checkOutput("hold_data", m_data, held_data);
      end
      if (track_en && busy) begin
        idx = ram_addr - cur_base;
        checks++;
        if (int'(idx) > accepted + 2) begin
          errors++;
          $display("[TB] FAIL addr_ahead: got lead %0d expected at most %0d", idx, accepted + 2);
        end
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL extra_word: got %0h expected no word", m_data);
        end else begin
          checkOutput("stream_data", m_data, exp_q.pop_front());
        end
        accepted++;
      end
      stalled   = m_valid && !m_ready;
      held_data = m_data;
    end
  end

  task automatic applyStimulus(input logic [9:0] b, input logic [10:0] n);
    logic [9:0] a;
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = b;
    len       = n;
    cur_base  = b;
    accepted  = 0;
    track_en  = (n != 0);
    for (int i = 0; i < int'(n); i++) begin
      a = b + 10'(i);
      exp_q.push_back(mem[a]);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int limit, input bit toggle, input logic [9:0] fin_addr);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 0;
    while (cyc < limit && !seen) begin
      @(negedge clk);
      if (done_tick) begin
        seen = 1;
      end else begin
        @(posedge clk); #1;
        m_ready = toggle ? pat[cyc % 6] : 1'b1;
        cyc++;
      end
    end
    checkOutput("done_seen", 32'(seen), 1);
    if (seen) begin
      checkOutput("ram_addr_final", ram_addr, fin_addr);
      checkOutput("sb_empty", exp_q.size(), 0);
      @(negedge clk);
      checkOutput("busy_after_done", busy, 0);
      checkOutput("done_width", done_tick, 0);
    end
    track_en = 0;
    m_ready  = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] a0;
    reset_n   = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    m_ready   = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done_tick, 0);
    checkOutput("rst_we", ram_we, 0);
    checkOutput("rst_addr", ram_addr, 0);
    checkOutput("rst_valid", m_valid, 0);
    checkOutput("rst_data", m_data, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // base=5 len=4 with exact cycle timing.
    applyStimulus(10'd5, 11'd4);
    @(negedge clk);
    checkOutput("t1_addr", ram_addr, 5);
    checkOutput("t1_busy", busy, 1);
    checkOutput("t1_valid_k", m_valid, 0);
    @(negedge clk);
    checkOutput("t1_valid_k1", m_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("t1_valid_run", m_valid, 1);
    end
    @(negedge clk);
    checkOutput("t1_done", done_tick, 1);
    checkOutput("t1_valid_end", m_valid, 0);
    @(negedge clk);
    checkOutput("t1_done_off", done_tick, 0);
    checkOutput("t1_busy_off", busy, 0);
    track_en = 0;
    checkOutput("t1_sb_empty", exp_q.size(), 0);

    // Wrap across the top of the address space.
    applyStimulus(10'd1022, 11'd4);
    waitDone(50, 0, 10'd1);

    // Backpressure with a stall pattern.
    m_ready = 1'b1;
    applyStimulus(10'd0, 11'd6);
    waitDone(100, 1, 10'd5);

    // Zero-length burst.
    @(negedge clk);
    a0 = ram_addr;
    applyStimulus(10'd7, 11'd0);
    @(negedge clk);
    checkOutput("len0_done", done_tick, 1);
    checkOutput("len0_valid", m_valid, 0);
    checkOutput("len0_addr", ram_addr, a0);
    @(negedge clk);
    checkOutput("len0_done_off", done_tick, 0);
    checkOutput("len0_busy_off", busy, 0);

    // Second start while busy must be ignored.
    applyStimulus(10'd20, 11'd5);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = 10'd100;
    len       = 11'd3;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(60, 0, 10'd24);

    // Full-depth burst.
    applyStimulus(10'd3, 11'd1024);
    waitDone(1200, 0, 10'd2);

    // Reset in the middle of a burst, then a fresh burst.
    applyStimulus(10'd0, 11'd8);
    repeat (3) @(posedge clk);
    #1;
    reset_n  = 1'b0;
    track_en = 0;
    #1;
    checkOutput("mid_rst_valid", m_valid, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_addr", ram_addr, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(10'd10, 11'd2);
    waitDone(50, 0, 10'd11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
